jet_class_argmax: RTL and testbench

Sequential output-classification stage for the Jet Tagging network. It accepts the NCLASS signed fixed-point logits produced by the final dense layer (dense_4: 32 inputs, 5 outputs, 25-bit, 12 fractional bits), scans them one class per cycle, and returns three values: the winning class index, the winning logit, and the saturated margin between the top two logits. It sits directly downstream of dense_4 and feeds the result/readout interface. Ready/valid handshakes are used on both sides.

---
 rtl/jet_class_argmax.sv | 181 ++++++++++++++++++
 tb/tb_jet_class_argmax.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jet_class_argmax.sv
// jet_class_argmax
// Output-classification stage of the Jet Tagging network. Takes the NCLASS
// signed logits of the final dense layer, walks them one class per cycle and
// reports the winning class, the winning logit and the saturated margin
// between the best and second-best logits.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous, active-high reset
//   in_valid   : in_logits holds a vector
//   in_ready   : block is idle and can take a vector
//   in_logits  : packed logits, class k at [k*WIDTH +: WIDTH]
//   out_valid  : result registers hold a valid result
//   out_ready  : consumer takes the result
//   out_class  : index of the largest logit (lowest index on ties)
//   out_max    : largest logit
//   out_margin : top1 - top2, clamped to 2^(WIDTH-1)-1
module jet_class_argmax #(
  parameter int WIDTH  = 25,
  parameter int NFRAC  = 12,
  parameter int NCLASS = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NCLASS*WIDTH-1:0]     in_logits,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(NCLASS)-1:0]   out_class,
  output logic [WIDTH-1:0]            out_max,
  output logic [WIDTH-1:0]            out_margin
);

  localparam int IW = $clog2(NCLASS);
  localparam logic [IW-1:0]           LAST_IDX = IW'(NCLASS - 1);
  localparam logic signed [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]          MAX_POS  = {2'b00, {(WIDTH-1){1'b1}}};

  // Elaboration-time parameter sanity: an argmax needs two classes, and the
  // fractional point has to sit inside the word.
  if (NCLASS < 2 || NFRAC < 0 || NFRAC >= WIDTH) begin : g_param_check
    $error("jet_class_argmax: illegal parameters");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic                       out_valid_q;
  logic [NCLASS*WIDTH-1:0]    logits_q;
  logic [IW-1:0]              idx_q;
  logic signed [WIDTH-1:0]    best_q, second_q;
  logic [IW-1:0]              best_idx_q;
  logic [IW-1:0]              out_class_q;
  logic [WIDTH-1:0]           out_max_q, out_margin_q;

  logic signed [WIDTH-1:0]    cur_s;
  logic signed [WIDTH-1:0]    best_d, second_d;
  logic [IW-1:0]              best_idx_d;
  logic [WIDTH:0]             diff_s;
  logic [WIDTH-1:0]           margin_s;
  logic                       accept_s;

  assign accept_s = in_valid && in_ready;

  // State register; out_valid is registered from the next state so it has
  // no combinational dependence on out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = SCAN;
        else          state_d = IDLE;
      end
      SCAN: begin
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   state_d = SCAN;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: input side is ready only when idle and out of reset.
  always_comb begin
    in_ready = 1'b0;
    if (state_q == IDLE && !reset) in_ready = 1'b1;
    else                           in_ready = 1'b0;
  end

  // One scan step: the current class sits in the low word of the shifted
  // capture register. Strict compare keeps the lower index on ties.
  always_comb begin
    cur_s      = logits_q[WIDTH-1:0];
    best_d     = best_q;
    second_d   = second_q;
    best_idx_d = best_idx_q;
    if (cur_s > best_q) begin
      second_d   = best_q;
      best_d     = cur_s;
      best_idx_d = idx_q;
    end else if (cur_s > second_q) begin
      second_d   = cur_s;
    end else begin
      second_d   = second_q;
    end
  end

  // Margin at WIDTH+1 bits; best >= second so the difference is never
  // negative and only the upper clamp is needed.
  always_comb begin
    diff_s = {best_d[WIDTH-1], best_d} - {second_d[WIDTH-1], second_d};
    if (diff_s > MAX_POS) margin_s = MAX_POS[WIDTH-1:0];
    else                  margin_s = diff_s[WIDTH-1:0];
  end

  // Datapath: capture on accept, shift and track top-two during scan,
  // latch the result on the last class. Results hold outside SCAN.
  always_ff @(posedge clk) begin
    if (reset) begin
      logits_q     <= {(NCLASS*WIDTH){1'b0}};
      idx_q        <= {IW{1'b0}};
      best_q       <= {WIDTH{1'b0}};
      second_q     <= {WIDTH{1'b0}};
      best_idx_q   <= {IW{1'b0}};
      out_class_q  <= {IW{1'b0}};
      out_max_q    <= {WIDTH{1'b0}};
      out_margin_q <= {WIDTH{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            logits_q   <= in_logits;
            idx_q      <= {IW{1'b0}};
            best_q     <= MIN_VAL;
            second_q   <= MIN_VAL;
            best_idx_q <= {IW{1'b0}};
          end
        end
        SCAN: begin
          logits_q   <= logits_q >> WIDTH;
          idx_q      <= idx_q + IW'(1);
          best_q     <= best_d;
          second_q   <= second_d;
          best_idx_q <= best_idx_d;
          if (idx_q == LAST_IDX) begin
            out_class_q  <= best_idx_d;
            out_max_q    <= best_d;
            out_margin_q <= margin_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_class  = out_class_q;
  assign out_max    = out_max_q;
  assign out_margin = out_margin_q;

endmodule

// File: tb/tb_jet_class_argmax.sv
module tb_jet_class_argmax;

  localparam int W  = 25;
  localparam int N  = 5;
  localparam int IW = $clog2(N);

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [N*W-1:0]    in_logits;
  logic              out_valid;
  logic              out_ready;
  logic [IW-1:0]     out_class;
  logic [W-1:0]      out_max;
  logic [W-1:0]      out_margin;

  jet_class_argmax #(.WIDTH(W), .NFRAC(12), .NCLASS(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_logits  (in_logits),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_max    (out_max),
    .out_margin (out_margin)
  );

  typedef struct {
    int     cls;
    longint mx;
    longint mg;
    int     t;    // cycle count just after the accept edge
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  bit     b2b = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: argmax with lowest-index tie-break, then the largest of the
  // remaining values, margin clamped to the largest positive word.
  function automatic exp_t model(input logic [N*W-1:0] v);
    longint vals[N];
    logic signed [W-1:0] t;
    exp_t e;
    int bi;
    longint sec;
    longint maxpos;
    maxpos = (64'sd1 <<< (W-1)) - 64'sd1;
    for (int k = 0; k < N; k++) begin
      t = v[k*W +: W];
      vals[k] = t;
    end
    bi = 0;
    for (int k = 1; k < N; k++) if (vals[k] > vals[bi]) bi = k;
    sec = -(64'sd1 <<< (W-1));
    for (int k = 0; k < N; k++) if (k != bi && vals[k] > sec) sec = vals[k];
    e.cls = bi;
    e.mx  = vals[bi];
    e.mg  = (vals[bi] - sec > maxpos) ? maxpos : vals[bi] - sec;
    e.t   = 0;
    return e;
  endfunction

  function automatic logic [N*W-1:0] pk5(input longint a0, input longint a1,
                                         input longint a2, input longint a3,
                                         input longint a4);
    return {a4[W-1:0], a3[W-1:0], a2[W-1:0], a1[W-1:0], a0[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic signed [W-1:0] s;
    case ($urandom_range(0, 5))
      0, 1:    s = W'($urandom);
      2, 3:    s = W'($urandom_range(0, 16)) - W'(8);
      4:       s = {1'b1, {(W-1){1'b0}}};
      default: s = {1'b0, {(W-1){1'b1}}};
    endcase
    return s;
  endfunction

  // Monitor / scoreboard: push expected on accept, check latency when
  // out_valid rises, pop and compare on each output handshake.
  initial begin
    bit     prev_ov;
    int     b2b_cnt;
    int     last_acc;
    exp_t   e;
    prev_ov  = 1'b0;
    b2b_cnt  = 0;
    last_acc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        prev_ov = 1'b0;
        b2b_cnt = 0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (exp_q.size() == 0) check("out_valid_unexpected", out_valid, 0);
          else                   check("latency", cyc - exp_q[0].t, N);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("result_unexpected", out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_class",  out_class, e.cls);
            check("out_max",    longint'($signed(out_max)), e.mx);
            check("out_margin", out_margin, e.mg);
          end
        end
        if (in_valid && in_ready) begin
          e   = model(in_logits);
          e.t = cyc + 1;
          exp_q.push_back(e);
          if (b2b) begin
            if (b2b_cnt > 0) check("initiation_interval", cyc + 1 - last_acc, 7);
            b2b_cnt++;
            last_acc = cyc + 1;
          end
        end
        if (!b2b) b2b_cnt = 0;
        prev_ov = out_valid;
      end
    end
  end

  // Present a vector and wait (bounded) for its accept edge; returns just
  // after that edge.
  task automatic send(input logic [N*W-1:0] v, input bit keep);
    bit acc;
    in_logits = v;
    in_valid  = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", acc, 1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [IW-1:0] sc;
    logic [W-1:0]  sm, sg;
    int            d_cyc;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_logits = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid",  out_valid, 0);
    check("rst_in_ready",   in_ready, 0);
    check("rst_out_class",  out_class, 0);
    check("rst_out_max",    out_max, 0);
    check("rst_out_margin", out_margin, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed vectors: bias, tie, saturation
    send(pk5(-255, -257, -288, 336, 882), 1'b0);
    wait_drain();
    send(pk5(100, 100, 100, 100, 100), 1'b0);
    wait_drain();
    send(pk5(16777215, -16777216, -16777216, -16777216, -16777216), 1'b0);
    wait_drain();

    // Backpressure with a second vector waiting upstream
    out_ready = 1'b0;
    send(pk5(7, -3, 7, 1, 2), 1'b0);
    in_logits = pk5(-9, 40, 12, 40, -100);
    in_valid  = 1'b1;
    for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
    check("bp_out_valid", out_valid, 1);
    sc = out_class;
    sm = out_max;
    sg = out_margin;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold_valid",  out_valid, 1);
      check("bp_hold_class",  out_class, sc);
      check("bp_hold_max",    out_max, sm);
      check("bp_hold_margin", out_margin, sg);
      check("bp_in_ready",    in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    d_cyc = cyc;
    check("bp_in_ready_d1", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
    // first negedge with out_valid is inside cycle D+7 (after edge D+6)
    check("bp_second_latency", cyc - d_cyc, 6);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of a scan (sampled at edge T+3)
    send(pk5(1, 2, 3, 4, 50), 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midscan_out_valid", out_valid, 0);
    check("midscan_in_ready",  in_ready, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("midscan_no_result", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(pk5(0, 0, 0, 0, 5), 1'b0);
    wait_drain();

    // Back-to-back random vectors, in_valid held high, out_ready tied high
    out_ready = 1'b1;
    b2b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(pk5(longint'(rnd_word()), longint'(rnd_word()), longint'(rnd_word()),
               longint'(rnd_word()), longint'(rnd_word())), 1'b1);
    end
    in_valid = 1'b0;
    wait_drain();
    b2b = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
